// File: rtl/division_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One operation in flight. Divide-by-zero and signed overflow complete in one cycle.
module division_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             data_valid_i,
  input  logic [1:0]       operation_i,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             idle_o,
  output logic             data_valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIVIDE   = 2'd1;
  localparam logic [1:0] FINALIZE = 2'd2;
  localparam int CNT_W = $clog2(XLEN);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [XLEN-1:0]  quo_reg;
  logic [XLEN-1:0]  divisor_reg;
  logic             is_rem_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [XLEN-1:0]  result_reg;
  logic [TAG_W-1:0] tag_out_reg;
  logic             valid_reg;

  // Operand preparation; DIV and REM have operation bit 0 clear.
  logic            is_signed;
  logic            is_rem;
  logic            dividend_neg;
  logic            divisor_neg;
  logic [XLEN-1:0] dividend_abs;
  logic [XLEN-1:0] divisor_abs;
  logic            div_by_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_result;

  assign is_signed    = ~operation_i[0];
  assign is_rem       = operation_i[1];
  assign dividend_neg = is_signed & dividend_i[XLEN-1];
  assign divisor_neg  = is_signed & divisor_i[XLEN-1];
  assign dividend_abs = dividend_neg ? -dividend_i : dividend_i;
  assign divisor_abs  = divisor_neg ? -divisor_i : divisor_i;
  assign div_by_zero  = (divisor_i == '0);
  assign overflow     = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                        && (divisor_i == {XLEN{1'b1}});
  assign special      = div_by_zero | overflow;

  always_comb begin
    special_result = '0;
    if (div_by_zero) special_result = is_rem ? dividend_i : {XLEN{1'b1}};
    else             special_result = is_rem ? '0 : dividend_i;
  end

  // One restoring step; the shifted remainder needs XLEN+1 bits for large unsigned divisors.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
  assign trial     = rem_shift - {1'b0, divisor_reg};
  assign rem_next  = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next  = {quo_reg[XLEN-2:0], ~trial[XLEN]};

  logic [XLEN-1:0] pick;
  logic            pick_neg;
  logic [XLEN-1:0] final_result;

  assign pick         = is_rem_reg ? rem_reg : quo_reg;
  assign pick_neg     = is_rem_reg ? neg_r_reg : neg_q_reg;
  assign final_result = pick_neg ? -pick : pick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      is_rem_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      tag_reg     <= '0;
      result_reg  <= '0;
      tag_out_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (flush_i) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (data_valid_i) begin
              is_rem_reg <= is_rem;
              neg_q_reg  <= dividend_neg ^ divisor_neg;
              neg_r_reg  <= dividend_neg;
              tag_reg    <= tag_i;
              if (special) begin
                result_reg  <= special_result;
                tag_out_reg <= tag_i;
                valid_reg   <= 1'b1;
              end else begin
                state_reg   <= DIVIDE;
                rem_reg     <= '0;
                quo_reg     <= dividend_abs;
                divisor_reg <= divisor_abs;
                cnt_reg     <= CNT_W'(XLEN - 1);
              end
            end
          end
          DIVIDE: begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            if (cnt_reg == '0) state_reg <= FINALIZE;
            else               cnt_reg   <= cnt_reg - 1'b1;
          end
          FINALIZE: begin
            result_reg  <= final_result;
            tag_out_reg <= tag_reg;
            valid_reg   <= 1'b1;
            state_reg   <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign idle_o       = (state_reg == IDLE);
  assign data_valid_o = valid_reg;
  assign result_o     = result_reg;
  assign tag_o        = tag_out_reg;

endmodule
